seg7_scan_display: RTL

//  Downstream display stage of the onBoard top. Takes the 16-bit CPU register value selected by select_y and shows it
//  as 4 hex digits on the time-multiplexed 7-segment display.

---
 rtl/seg7_scan_display_pkg.sv | 40 ++++
 rtl/seg7_scan_display_if.sv | 23 ++
 rtl/seg7_scan_display_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_display.sv | 86 ++++++++
 4 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants, output bundle and helpers for the 4-digit
// multiplexed 7-segment display stage.
package seg7_scan_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] GA_OFF    = 4'hF;
    localparam int         DIGITS    = 4;
    localparam int         IDX_W     = $clog2(DIGITS);

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F
    localparam logic [6:0] HEX2SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] ga;
        logic       frame_done;
    } disp_out_t;

    localparam disp_out_t OUT_RST = '{
        seg:        SEG_BLANK,
        ga:         GA_OFF,
        frame_done: 1'b0
    };

    // Digit i is a leading zero when every nibble from i upward is 0
    function automatic logic lead_zero(
        input logic [15:0]      v,
        input logic [IDX_W-1:0] i
    );
        logic [15:0] hi;
        hi = v >> {i, 2'b00};
        return (i != '0) && (hi == 16'h0000);
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Host-side bus of the display stage: value/strobe controls in,
// active-low segment/anode drive and frame pulse out.
interface seg7_scan_display_if;

    logic        enable;
    logic [15:0] data_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  ga;
    logic        frame_done;

    modport master (
        output enable, data_in, load, blank_lz,
        input  seg, ga, frame_done
    );

    modport slave (
        input  enable, data_in, load, blank_lz,
        output seg, ga, frame_done
    );

endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = HEX2SEG[digit];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit hex display with a double-buffered value
// that only swaps at frame boundaries, so digits never tear.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    seg7_scan_display_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [15:0]      shadow;
    logic [15:0]      disp;
    logic             pending;
    disp_out_t        out_q;

    logic       tick;
    logic       boundary;
    logic [3:0] nibble;
    logic [6:0] dec;
    logic       dark;

    assign tick     = bus.enable && (cnt == CNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign nibble   = disp[{idx, 2'b00} +: 4];
    assign dark     = bus.blank_lz && lead_zero(disp, idx);

    hex_to_seg7 u_dec (
        .digit (nibble),
        .seg   (dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
            out_q   <= OUT_RST;
        end else begin
            if (tick) begin
                cnt <= '0;
                idx <= idx + 1'b1;
            end else if (bus.enable) begin
                cnt <= cnt + 1'b1;
            end

            if (bus.load) begin
                shadow  <= bus.data_in;
                pending <= 1'b1;
            end

            // Same-cycle load bypasses the shadow so it is not a frame late
            if (boundary) begin
                pending <= 1'b0;
                if (bus.load)
                    disp <= bus.data_in;
                else if (pending)
                    disp <= shadow;
            end

            out_q.frame_done <= boundary;

            if (bus.enable) begin
                out_q.ga  <= ~(4'b0001 << idx);
                out_q.seg <= dark ? SEG_BLANK : dec;
            end else begin
                out_q.ga  <= GA_OFF;
                out_q.seg <= SEG_BLANK;
            end
        end
    end

    assign bus.seg        = out_q.seg;
    assign bus.ga         = out_q.ga;
    assign bus.frame_done = out_q.frame_done;

endmodule
